wb_write_port: RTL and testbench

Writeback arbiter that owns the single write port of `register_file`. It merges in-order results from the MEM/WB pipeline register with out-of-order results from the iterative M-extension (mul/div) unit, buffers the latter in a small FIFO, and drives `reg_write`/`write_data`/`writeenable`. It also exports a pending-destination mask so decode can detect hazards against buffered results.

---
 rtl/rv_wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 88 ++++++++
 rtl/wb_write_port.sv | 88 ++++++++
 tb/tb_wb_write_port.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared types and constants for the writeback port
package rv_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [XLEN-1:0] one;
        one = {{(XLEN-1){1'b0}}, 1'b1};
        return one << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - mul/div result buffer with squash-by-rd and live destination mask
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [REG_AW-1:0] squash_rd,
    output logic              full,
    output logic              empty,
    output wb_entry_t         head,
    output logic [XLEN-1:0]   live_rd_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [DEPTH-1:0]  live_eff;
    logic              push_live;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Live bits already reflect this cycle's squash so the mask and head agree with it.
    always_comb begin
        live_rd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_eff[i] = mem[i].live && !(squash_en && (mem[i].rd == squash_rd));
            if (live_eff[i]) begin
                live_rd_mask = live_rd_mask | rd_onehot(mem[i].rd);
            end
        end
    end

    always_comb begin
        head      = mem[rd_ptr];
        head.live = live_eff[rd_ptr] && !empty;
    end

    assign push_live = !(squash_en && (push_rd == squash_rd));

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].live <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].live <= live_eff[i];
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr].live <= push_live;
                mem[wr_ptr].rd   <= push_rd;
                mem[wr_ptr].data <= push_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/wb_write_port.sv
// rtl/wb_write_port.sv - register file write port arbiter; WB_MD_BYPASS_EN enables empty-FIFO bypass
module wb_write_port
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_rd,
    input  logic [XLEN-1:0]   md_data,
    output logic [REG_AW-1:0] reg_write,
    output logic [XLEN-1:0]   write_data,
    output logic              writeenable,
    output logic [XLEN-1:0]   pend_mask
);

    logic      slot_busy;
    logic      fifo_full;
    logic      fifo_empty;
    wb_entry_t fifo_head;
    logic      md_accept;
    logic      md_bypass;
    logic      fifo_push;
    logic      fifo_pop;
    logic      drain;

    assign slot_busy = pipe_valid && pipe_we && (pipe_rd != '0);
    assign md_ready  = !fifo_full && !rst;
    assign md_accept = md_valid && md_ready;

`ifdef WB_MD_BYPASS_EN
    assign md_bypass = md_accept && fifo_empty && !slot_busy && (md_rd != '0);
`else
    assign md_bypass = 1'b0;
`endif

    assign fifo_push = md_accept && (md_rd != '0) && !md_bypass;

    // A squashed head leaves regardless of the slot; a live head only when the slot is free.
    assign drain    = fifo_head.live && !slot_busy;
    assign fifo_pop = !fifo_empty && (!fifo_head.live || !slot_busy);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (fifo_push),
        .push_rd      (md_rd),
        .push_data    (md_data),
        .pop          (fifo_pop),
        .squash_en    (slot_busy),
        .squash_rd    (pipe_rd),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head         (fifo_head),
        .live_rd_mask (pend_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            writeenable <= 1'b0;
            reg_write   <= '0;
            write_data  <= '0;
        end else if (slot_busy) begin
            writeenable <= 1'b1;
            reg_write   <= pipe_rd;
            write_data  <= pipe_data;
        end else if (drain) begin
            writeenable <= 1'b1;
            reg_write   <= fifo_head.rd;
            write_data  <= fifo_head.data;
        end else if (md_bypass) begin
            writeenable <= 1'b1;
            reg_write   <= md_rd;
            write_data  <= md_data;
        end else begin
            writeenable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_port.sv
// tb/tb_wb_write_port.sv - directed self-checking bench for wb_write_port
module tb_wb_write_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  reg_write;
    logic [31:0] write_data;
    logic        writeenable;
    logic [31:0] pend_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_write_port #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_valid),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_rd       (md_rd),
        .md_data     (md_data),
        .reg_write   (reg_write),
        .write_data  (write_data),
        .writeenable (writeenable),
        .pend_mask   (pend_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] data);
        check({tag, "_we"}, {31'd0, writeenable}, {31'd0, we});
        if (we) begin
            check({tag, "_rd"}, {27'd0, reg_write}, {27'd0, rd});
            check({tag, "_data"}, write_data, data);
        end
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v;
        pipe_we    = v;
        pipe_rd    = rd;
        pipe_data  = d;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
        md_valid = v;
        md_rd    = rd;
        md_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("rst_we", {31'd0, writeenable}, 32'd0);
        check("rst_rd", {27'd0, reg_write}, 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_ready", {31'd0, md_ready}, 32'd0);
        check("rst_pend", pend_mask, 32'd0);

        // Basic pipeline write
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, md_ready}, 32'd1);
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_port("pipe_basic", 1'b1, 5'd5, 32'hDEADBEEF);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_port("pipe_idle", 1'b0, 5'd0, 32'd0);

        // Fill FIFO behind a busy pipeline, then drain in order
        set_pipe(1'b1, 5'd1, 32'h100);
        set_md(1'b1, 5'd10, 32'hA);
        #1;
        check("fill_ready0", {31'd0, md_ready}, 32'd1);
        tick();
        check_port("fill_p0", 1'b1, 5'd1, 32'h100);
        set_pipe(1'b1, 5'd1, 32'h101);
        set_md(1'b1, 5'd11, 32'hB);
        #1;
        check("fill_ready1", {31'd0, md_ready}, 32'd1);
        tick();
        check_port("fill_p1", 1'b1, 5'd1, 32'h101);
        set_pipe(1'b1, 5'd1, 32'h102);
        set_md(1'b1, 5'd12, 32'hC);
        #1;
        check("fill_ready_full", {31'd0, md_ready}, 32'd0);
        check("fill_pend", pend_mask, 32'h0000_0C00);
        tick();
        check_port("fill_p2", 1'b1, 5'd1, 32'h102);
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        #1;
        check("drain_ready_full", {31'd0, md_ready}, 32'd0);
        tick();
        check_port("drain0", 1'b1, 5'd10, 32'hA);
        check("drain_ready1", {31'd0, md_ready}, 32'd1);
        check("drain_pend1", pend_mask, 32'h0000_0800);
        tick();
        check_port("drain1", 1'b1, 5'd11, 32'hB);
        check("drain_pend2", pend_mask, 32'd0);
        tick();
        check_port("drain_done", 1'b0, 5'd0, 32'd0);

        // WAW squash of a buffered rd=7 result
        set_pipe(1'b1, 5'd2, 32'h22);
        set_md(1'b1, 5'd7, 32'h77);
        tick();
        check_port("waw_p", 1'b1, 5'd2, 32'h22);
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        #1;
        check("waw_pend_set", pend_mask, 32'h0000_0080);
        set_pipe(1'b1, 5'd7, 32'h11);
        #1;
        check("waw_pend_clr", pend_mask, 32'd0);
        tick();
        check_port("waw_win", 1'b1, 5'd7, 32'h11);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_port("waw_no_stale", 1'b0, 5'd0, 32'd0);
        check("waw_ready", {31'd0, md_ready}, 32'd1);
        tick();
        check_port("waw_no_stale2", 1'b0, 5'd0, 32'd0);

        // Writes to x0 from both sources are dropped and never enqueued
        pipe_valid = 1'b1;
        pipe_we    = 1'b1;
        pipe_rd    = 5'd0;
        pipe_data  = 32'hBAD;
        set_md(1'b1, 5'd0, 32'hBAD0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0_ready", {31'd0, md_ready}, 32'd1);
            tick();
            check_port("x0_we", 1'b0, 5'd0, 32'd0);
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        #1;
        check("x0_pend", pend_mask, 32'd0);

        // Mul/div latency with an idle pipeline
        set_md(1'b1, 5'd3, 32'h42);
        tick();
        set_md(1'b0, 5'd0, 32'd0);
`ifdef WB_MD_BYPASS_EN
        check_port("lat_n1", 1'b1, 5'd3, 32'h42);
        tick();
        check_port("lat_n2", 1'b0, 5'd0, 32'd0);
`else
        check_port("lat_n1", 1'b0, 5'd0, 32'd0);
        tick();
        check_port("lat_n2", 1'b1, 5'd3, 32'h42);
`endif
        tick();
        check_port("lat_after", 1'b0, 5'd0, 32'd0);

        // Reset pulse with a full FIFO
        set_pipe(1'b1, 5'd1, 32'h200);
        set_md(1'b1, 5'd20, 32'hD);
        tick();
        set_md(1'b1, 5'd21, 32'hE);
        tick();
        set_md(1'b0, 5'd0, 32'd0);
        #1;
        check("mrst_full", {31'd0, md_ready}, 32'd0);
        check("mrst_pend", pend_mask, 32'h0030_0000);
        rst = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("mrst_ready_in_rst", {31'd0, md_ready}, 32'd0);
        tick();
        check("mrst_we", {31'd0, writeenable}, 32'd0);
        check("mrst_rd", {27'd0, reg_write}, 32'd0);
        check("mrst_data", write_data, 32'd0);
        check("mrst_pend_clr", pend_mask, 32'd0);
        rst = 1'b0;
        #1;
        check("mrst_ready_after", {31'd0, md_ready}, 32'd1);
        tick();
        check_port("mrst_stale0", 1'b0, 5'd0, 32'd0);
        tick();
        check_port("mrst_stale1", 1'b0, 5'd0, 32'd0);
        check("mrst_pend_end", pend_mask, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
